// File: rtl/mc_controller.sv
// Multicycle RISC-V control unit: Moore state machine plus ALU and immediate decoders.
// Optional jal support is enabled by defining MC_CONTROLLER_JAL_EN.
module mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegWrite,
  output logic [1:0] ImmSrc,
  output logic [1:0] ALUControl,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    ALUWB    = 4'd7,
    EXECUTEI = 4'd8,
    JAL      = 4'd9,
    BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  state_t     st;
  logic [1:0] alu_op;
  logic       pc_upd, mem_wr, ir_wr, reg_wr;

  assign state = st;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) st <= FETCH;
    else begin
      case (st)
        FETCH:  st <= DECODE;
        DECODE: begin
          case (op)
            OP_LW, OP_SW: st <= MEMADR;
            OP_R:         st <= EXECUTER;
            OP_I:         st <= EXECUTEI;
            OP_BEQ:       st <= BEQ;
`ifdef MC_CONTROLLER_JAL_EN
            OP_JAL:       st <= JAL;
`endif
            default:      st <= FETCH;
          endcase
        end
        MEMADR:   st <= (op == OP_LW) ? MEMREAD : MEMWRITE;
        MEMREAD:  st <= MEMWB;
        EXECUTER: st <= ALUWB;
        EXECUTEI: st <= ALUWB;
`ifdef MC_CONTROLLER_JAL_EN
        JAL:      st <= ALUWB;
`endif
        default:  st <= FETCH;
      endcase
    end
  end

  // Outputs decode from the state register alone, except BEQ's PCWrite which tracks Zero.
  always_comb begin
    pc_upd    = 1'b0;
    AdrSrc    = 1'b0;
    mem_wr    = 1'b0;
    ir_wr     = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    reg_wr    = 1'b0;
    alu_op    = 2'b00;
    case (st)
      FETCH: begin
        ir_wr     = 1'b1;
        pc_upd    = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      MEMREAD:  AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        reg_wr    = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        mem_wr = 1'b1;
      end
      EXECUTER: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b10;
      end
      EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = 2'b10;
      end
      ALUWB:    reg_wr = 1'b1;
`ifdef MC_CONTROLLER_JAL_EN
      JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        pc_upd  = 1'b1;
      end
`endif
      BEQ: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b01;
        pc_upd  = Zero;
      end
      default: ;
    endcase
  end

  // Reset gates only the write strobes; the state register already reads FETCH.
  assign PCWrite  = pc_upd & ~reset;
  assign MemWrite = mem_wr & ~reset;
  assign IRWrite  = ir_wr  & ~reset;
  assign RegWrite = reg_wr & ~reset;

  always_comb begin
    ALUControl = 2'b00;
    case (alu_op)
      2'b01: ALUControl = 2'b01;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = (op[5] & funct7b5) ? 2'b01 : 2'b00;
          3'b111:  ALUControl = 2'b10;
          3'b110:  ALUControl = 2'b11;
          default: ALUControl = 2'b00;
        endcase
      end
      default: ALUControl = 2'b00;
    endcase
  end

  always_comb begin
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
`ifdef MC_CONTROLLER_JAL_EN
      OP_JAL:  ImmSrc = 2'b11;
`endif
      default: ImmSrc = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: walks each instruction class through its state
// sequence and checks outputs against hand-computed values, including async reset.
module tb_mc_controller;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] op = 7'b0000011;
  logic [2:0] funct3 = 3'b000;
  logic       funct7b5 = 1'b0;
  logic       Zero = 1'b0;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .RegWrite(RegWrite), .ImmSrc(ImmSrc), .ALUControl(ALUControl), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Packs the four write strobes as {PCWrite, IRWrite, MemWrite, RegWrite}.
  function automatic logic [7:0] strobes();
    return {4'b0, PCWrite, IRWrite, MemWrite, RegWrite};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Asynchronous reset before any clock edge
    #1 reset = 1'b1;
    #1;
    chk("rst_state", {4'b0, state}, 8'd0);
    chk("rst_strobes", strobes(), 8'b0000);
    chk("rst_alusrcb", {6'b0, ALUSrcB}, 8'd2);
    chk("rst_resultsrc", {6'b0, ResultSrc}, 8'd2);
    step();
    step();
    chk("rst_hold_state", {4'b0, state}, 8'd0);
    @(negedge clk) reset = 1'b0;
    #1;
    chk("fetch_strobes", strobes(), 8'b1100);
    chk("fetch_adrsrc", {7'b0, AdrSrc}, 8'd0);

    // lw: 0,1,2,3,4,0
    op = 7'b0000011;
    step(); chk("lw_s1", {4'b0, state}, 8'd1);
    chk("lw_dec_src", {4'b0, ALUSrcA, ALUSrcB}, 8'b0101);
    chk("lw_dec_strobes", strobes(), 8'b0000);
    chk("lw_immsrc", {6'b0, ImmSrc}, 8'd0);
    step(); chk("lw_s2", {4'b0, state}, 8'd2);
    chk("lw_adr_src", {4'b0, ALUSrcA, ALUSrcB}, 8'b1001);
    step(); chk("lw_s3", {4'b0, state}, 8'd3);
    chk("lw_rd_adrsrc", {7'b0, AdrSrc}, 8'd1);
    chk("lw_rd_strobes", strobes(), 8'b0000);
    step(); chk("lw_s4", {4'b0, state}, 8'd4);
    chk("lw_wb_strobes", strobes(), 8'b0001);
    chk("lw_wb_resultsrc", {6'b0, ResultSrc}, 8'd1);
    step(); chk("lw_s0", {4'b0, state}, 8'd0);

    // sw: 0,1,2,5,0
    op = 7'b0100011;
    #1 chk("sw_immsrc", {6'b0, ImmSrc}, 8'd1);
    step(); step(); chk("sw_s2", {4'b0, state}, 8'd2);
    step(); chk("sw_s5", {4'b0, state}, 8'd5);
    chk("sw_wr_strobes", strobes(), 8'b0010);
    chk("sw_wr_adrsrc", {7'b0, AdrSrc}, 8'd1);
    step(); chk("sw_s0", {4'b0, state}, 8'd0);

    // R-type sub: 0,1,6,7,0
    op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;
    step(); step(); chk("sub_s6", {4'b0, state}, 8'd6);
    chk("sub_aluctl", {6'b0, ALUControl}, 8'd1);
    chk("sub_src", {4'b0, ALUSrcA, ALUSrcB}, 8'b1000);
    step(); chk("sub_s7", {4'b0, state}, 8'd7);
    chk("aluwb_strobes", strobes(), 8'b0001);
    chk("aluwb_resultsrc", {6'b0, ResultSrc}, 8'd0);
    step(); chk("sub_s0", {4'b0, state}, 8'd0);

    // R-type and / or decoded in EXECUTER
    funct3 = 3'b111; funct7b5 = 1'b0;
    step(); step(); chk("and_aluctl", {6'b0, ALUControl}, 8'd2);
    funct3 = 3'b110;
    #1 chk("or_aluctl", {6'b0, ALUControl}, 8'd3);
    funct3 = 3'b010;
    #1 chk("slt_aluctl_default", {6'b0, ALUControl}, 8'd0);
    step(); step(); chk("rt_back_s0", {4'b0, state}, 8'd0);

    // I-type addi with funct7b5=1 must still add: 0,1,8,7,0
    op = 7'b0010011; funct3 = 3'b000; funct7b5 = 1'b1;
    step(); step(); chk("addi_s8", {4'b0, state}, 8'd8);
    chk("addi_aluctl", {6'b0, ALUControl}, 8'd0);
    chk("addi_src", {4'b0, ALUSrcA, ALUSrcB}, 8'b1001);
    step(); chk("addi_s7", {4'b0, state}, 8'd7);
    step(); chk("addi_s0", {4'b0, state}, 8'd0);

    // beq: 0,1,10,0; PCWrite follows Zero within the cycle
    op = 7'b1100011; Zero = 1'b1; funct3 = 3'b000; funct7b5 = 1'b0;
    step(); chk("beq_immsrc", {6'b0, ImmSrc}, 8'd2);
    step(); chk("beq_s10", {4'b0, state}, 8'd10);
    chk("beq_taken_pcwrite", {7'b0, PCWrite}, 8'd1);
    chk("beq_aluctl", {6'b0, ALUControl}, 8'd1);
    Zero = 1'b0;
    #1 chk("beq_nottaken_pcwrite", {7'b0, PCWrite}, 8'd0);
    step(); chk("beq_s0", {4'b0, state}, 8'd0);

    // jal
    op = 7'b1101111;
`ifdef MC_CONTROLLER_JAL_EN
    #1 chk("jal_immsrc", {6'b0, ImmSrc}, 8'd3);
    step(); chk("jal_s1", {4'b0, state}, 8'd1);
    step(); chk("jal_s9", {4'b0, state}, 8'd9);
    chk("jal_pcwrite", strobes(), 8'b1000);
    chk("jal_src", {4'b0, ALUSrcA, ALUSrcB}, 8'b0110);
    step(); chk("jal_s7", {4'b0, state}, 8'd7);
    step(); chk("jal_s0", {4'b0, state}, 8'd0);
`else
    #1 chk("jal_off_immsrc", {6'b0, ImmSrc}, 8'd0);
    step(); chk("jal_off_s1", {4'b0, state}, 8'd1);
    chk("jal_off_dec_strobes", strobes(), 8'b0000);
    step(); chk("jal_off_s0", {4'b0, state}, 8'd0);
`endif

    // Illegal opcode: 0,1,0
    op = 7'b0000000;
    step(); chk("ill_s1", {4'b0, state}, 8'd1);
    step(); chk("ill_s0", {4'b0, state}, 8'd0);

    // Reset asserted mid-MEMREAD, away from any clock edge
    op = 7'b0000011;
    step(); step(); step(); chk("mid_s3", {4'b0, state}, 8'd3);
    reset = 1'b1;
    #1;
    chk("mid_rst_state", {4'b0, state}, 8'd0);
    chk("mid_rst_strobes", strobes(), 8'b0000);
    chk("mid_rst_adrsrc", {7'b0, AdrSrc}, 8'd0);
    @(negedge clk) reset = 1'b0;
    step(); chk("mid_after_rel_s1", {4'b0, state}, 8'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameters: none; all widths are fixed.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 op  in  7  instruction opcode field (instr[6:0]).
REQ-005 funct3  in  3  instruction funct3 field.
REQ-006 funct7b5  in  1  instr[30].
REQ-007 Zero  in  1  ALU zero flag from the alu stage.
REQ-008 PCWrite  out  1  PC register enable.
REQ-009 AdrSrc  out  1  memory address select: 0=PC, 1=ALU result register.
REQ-010 MemWrite  out  1  data memory write strobe.
REQ-011 IRWrite  out  1  instruction register enable.
REQ-012 ResultSrc  out  2  result mux select: 00=ALUOut, 01=Data, 10=ALUResult.
REQ-013 ALUSrcA  out  2  SrcA select: 00=PC, 01=OldPC, 10=register A.
REQ-014 ALUSrcB  out  2  SrcB select: 00=register B, 01=ImmExt, 10=constant 4.
REQ-015 RegWrite  out  1  register file write strobe.
REQ-016 ImmSrc  out  2  immediate format select.
REQ-017 ALUControl  out  2  alu operation: 00=add, 01=sub, 10=and, 11=or.
REQ-018 state  out  4  current FSM state, for debug.

Function
REQ-019 The block SHALL contain a Moore FSM with states FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, ALUWB=7, EXECUTEI=8, JAL=9, BEQ=10; codes 11-15 SHALL go to FETCH.
REQ-020 The FSM SHALL take these transitions:
- FETCH->DECODE.
- DECODE->MEMADR for lw (0000011) and sw (0100011); ->EXECUTER for R-type (0110011); ->EXECUTEI for I-type ALU (0010011); ->BEQ for beq (1100011); ->JAL for jal (1101111); ->FETCH for any other opcode.
- MEMADR->MEMREAD for lw, else ->MEMWRITE.
- MEMREAD->MEMWB.
- EXECUTER and EXECUTEI->ALUWB.
- JAL->ALUWB.
- MEMWB, MEMWRITE, ALUWB and BEQ->FETCH.
REQ-021 Any output not listed for a state SHALL be 0. Per-state outputs:
- FETCH: AdrSrc=0, IRWrite=1, PCWrite=1, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, ALUOp=00.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
- MEMREAD: AdrSrc=1, ResultSrc=00.
- MEMWB: ResultSrc=01, RegWrite=1.
- MEMWRITE: AdrSrc=1, MemWrite=1.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
- ALUWB: ResultSrc=00, RegWrite=1.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=Zero.
REQ-022 ALUOp is an internal 2-bit signal. ALUControl SHALL be combinational from ALUOp, funct3, op[5] and funct7b5:
- ALUOp 00 -> 00.
- ALUOp 01 -> 01.
- ALUOp 10, funct3 000 -> 01 if op[5] and funct7b5 are both 1, else 00.
- ALUOp 10, funct3 111 -> 10.
- ALUOp 10, funct3 110 -> 11.
- ALUOp 10, any other funct3 -> 00.
REQ-023 ImmSrc SHALL decode from op in every state: lw and I-type -> 00, sw -> 01, beq -> 10, jal -> 11, otherwise 00.
REQ-024 Latencies: lw 5 cycles, sw 4, R-type 4, I-type 4, beq 3, jal 4, illegal opcode 2.
REQ-025 In BEQ, PCWrite SHALL follow Zero combinationally within the cycle.

Reset
REQ-026 While reset=1, state SHALL be FETCH immediately, without waiting for a clock edge.
REQ-027 While reset=1, PCWrite, IRWrite, MemWrite and RegWrite SHALL be forced to 0; all other outputs hold their FETCH values.
REQ-028 Reset asserted mid-instruction SHALL abandon that instruction; the first edge after deassertion SHALL perform a FETCH.

Configuration
REQ-029 With macro MC_CONTROLLER_JAL_EN defined, the JAL state and jal decoding SHALL behave as specified above.
REQ-030 Without MC_CONTROLLER_JAL_EN, opcode 1101111 SHALL be treated as illegal (DECODE->FETCH) and SHALL give ImmSrc=00; state code 9 SHALL be unreachable.

Verification
REQ-031 Assert reset mid-MEMREAD with no clock edge -> state=0 and all four strobes 0 immediately; after release, the next edge gives state=1.
REQ-032 op=0000011 from FETCH -> state sequence 0,1,2,3,4,0; RegWrite=1 only in state 4 with ResultSrc=01.
REQ-033 op=0110011, funct3=000, funct7b5=1 -> ALUControl=01 in EXECUTER.
REQ-034 Same as REQ-033 but op=0010011 -> ALUControl=00 in EXECUTEI.
REQ-035 beq with Zero=1 -> PCWrite=1 in BEQ; with Zero=0 -> PCWrite=0; both return to FETCH after 3 cycles.
REQ-036 op=1101111 -> with MC_CONTROLLER_JAL_EN, states 0,1,9,7,0 and ImmSrc=11; without it, states 0,1,0 and no strobe asserted in DECODE.
